wb8_bus_arbiter: RTL and testbench

- Two-master, single-slave-port arbiter for the 8-bit Wishbone system bus.
- Lets a second master (DMA/debug loader) share the address decoder and peripherals with the CPU.
- Master 0 is the CPU and master 1 is the auxiliary master. The slave port drives the existing address decoder.
- Arbitration is round-robin with bus locking on CYC. A watchdog terminates transfers that the decoder never acknowledges.

---
 rtl/wb8_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_wb8_bus_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb8_bus_arbiter.sv
// Two-master, single-slave Wishbone (8-bit data) arbiter: round-robin with CYC
// bus locking, plus a watchdog that terminates transfers the decoder never acknowledges.
module wb8_bus_arbiter #(
  parameter int          TIMEOUT     = 255,
  parameter logic [7:0]  TIMEOUT_DAT = 8'hFF
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [7:0]  M0_DAT_I,
  output logic [7:0]  M0_DAT_O,
  output logic        M0_ACK_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [7:0]  M1_DAT_I,
  output logic [7:0]  M1_DAT_O,
  output logic        M1_ACK_O,
  output logic        S_CYC_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [31:0] S_ADR_O,
  output logic [7:0]  S_DAT_O,
  input  logic [7:0]  S_DAT_I,
  input  logic        S_ACK_I,
  output logic [1:0]  O_grant,
  output logic        O_timeout,
  output logic [31:0] O_timeout_adr
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last_owner;
  logic [7:0]  wd_cnt;
  logic        force_term;
  logic        slave_ack;
  logic [7:0]  ret_dat;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == OWN0) last_owner <= 1'b0;
      if (state == IDLE && state_nxt == OWN1) last_owner <= 1'b1;
    end
  end

  // Owners are only ever granted from IDLE, so every handover passes through one idle cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (M0_CYC_I && M1_CYC_I) state_nxt = last_owner ? OWN0 : OWN1;
        else if (M0_CYC_I)        state_nxt = OWN0;
        else if (M1_CYC_I)        state_nxt = OWN1;
      end
      OWN0:    if (!M0_CYC_I) state_nxt = IDLE;
      OWN1:    if (!M1_CYC_I) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    S_CYC_O = 1'b0;
    S_STB_O = 1'b0;
    S_WE_O  = 1'b0;
    S_ADR_O = 32'h0;
    S_DAT_O = 8'h00;
    case (state)
      OWN0: begin
        S_CYC_O = M0_CYC_I;
        S_STB_O = M0_STB_I;
        S_WE_O  = M0_WE_I;
        S_ADR_O = M0_ADR_I;
        S_DAT_O = M0_DAT_I;
      end
      OWN1: begin
        S_CYC_O = M1_CYC_I;
        S_STB_O = M1_STB_I;
        S_WE_O  = M1_WE_I;
        S_ADR_O = M1_ADR_I;
        S_DAT_O = M1_DAT_I;
      end
      default: ;
    endcase
  end

  // A real slave ACK in the timeout cycle wins over the forced termination.
  assign force_term = S_STB_O && !S_ACK_I && (wd_cnt == TIMEOUT_LAST);
  assign slave_ack  = S_ACK_I || force_term;
  assign ret_dat    = force_term ? TIMEOUT_DAT : S_DAT_I;

  assign M0_ACK_O = (state == OWN0) && slave_ack;
  assign M1_ACK_O = (state == OWN1) && slave_ack;
  assign M0_DAT_O = (state == OWN0) ? ret_dat : 8'h00;
  assign M1_DAT_O = (state == OWN1) ? ret_dat : 8'h00;
  assign O_grant  = {state == OWN1, state == OWN0};

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wd_cnt <= 8'h00;
    end else if (!S_STB_O || S_ACK_I || force_term) begin
      wd_cnt <= 8'h00;
    end else begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      O_timeout     <= 1'b0;
      O_timeout_adr <= 32'h0;
    end else if (force_term) begin
      O_timeout     <= 1'b1;
      O_timeout_adr <= S_ADR_O;
    end
  end

endmodule

// File: tb/tb_wb8_bus_arbiter.sv
// Directed self-checking bench for wb8_bus_arbiter (TIMEOUT = 8).
module tb_wb8_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr;
  logic [7:0]  m0_dat_w, m0_dat_r;
  logic        m0_ack;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr;
  logic [7:0]  m1_dat_w, m1_dat_r;
  logic        m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr;
  logic [7:0]  s_dat_w, s_dat_r;
  logic        s_ack;
  logic [1:0]  grant;
  logic        timeout;
  logic [31:0] timeout_adr;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  wb8_bus_arbiter #(.TIMEOUT(8), .TIMEOUT_DAT(8'hFF)) dut (
    .CLK_I(clk), .RST_I(rst),
    .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr),
    .M0_DAT_I(m0_dat_w), .M0_DAT_O(m0_dat_r), .M0_ACK_O(m0_ack),
    .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr),
    .M1_DAT_I(m1_dat_w), .M1_DAT_O(m1_dat_r), .M1_ACK_O(m1_ack),
    .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we), .S_ADR_O(s_adr),
    .S_DAT_O(s_dat_w), .S_DAT_I(s_dat_r), .S_ACK_I(s_ack),
    .O_grant(grant), .O_timeout(timeout), .O_timeout_adr(timeout_adr)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge, well clear of the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
    m0_adr = '0; m1_adr = '0; m0_dat_w = '0; m1_dat_w = '0; s_dat_r = '0;
    tick();
    tick();
    check_output("rst_grant", 32'(grant), 32'h0);
    check_output("rst_timeout", 32'(timeout), 32'h0);
    check_output("rst_timeout_adr", timeout_adr, 32'h0);
    check_output("rst_s_cyc_stb", 32'({s_cyc, s_stb}), 32'h0);
    check_output("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    rst = 1'b0;

    $display("[TB] M0 single read");
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010;
    tick();
    #1;
    check_output("rd_grant", 32'(grant), 32'h1);
    check_output("rd_s_adr", s_adr, 32'h0000_0010);
    s_ack = 1; s_dat_r = 8'h5A;
    #1;
    check_output("rd_m0_ack", 32'(m0_ack), 32'h1);
    check_output("rd_m0_dat", 32'(m0_dat_r), 32'h5A);
    check_output("rd_m1_ack", 32'(m1_ack), 32'h0);
    check_output("rd_m1_dat", 32'(m1_dat_r), 32'h0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    check_output("rd_idle_grant", 32'(grant), 32'h0);
    check_output("rd_idle_s_adr", s_adr, 32'h0);

    $display("[TB] Round-robin tie after reset");
    apply_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    check_output("rr_first", 32'(grant), 32'h1);
    m0_cyc = 0;
    tick();
    check_output("rr_gap", 32'(grant), 32'h0);
    tick();
    check_output("rr_second", 32'(grant), 32'h2);
    m1_cyc = 0;
    tick();
    check_output("rr_gap2", 32'(grant), 32'h0);
    m0_cyc = 1; m1_cyc = 1;
    tick();
    check_output("rr_third", 32'(grant), 32'h1);
    m0_cyc = 0; m1_cyc = 0;
    tick();

    $display("[TB] M1 burst locks out M0");
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0100;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      m1_adr = 32'h0000_0100 + 32'(i);
      s_ack = 1; s_dat_r = 8'(8'hA0 + i);
      #1;
      check_output("burst_grant", 32'(grant), 32'h2);
      check_output("burst_s_adr", s_adr, 32'h0000_0100 + 32'(i));
      check_output("burst_m1_dat", 32'(m1_dat_r), 32'(8'hA0 + i));
      check_output("burst_m0_ack", 32'(m0_ack), 32'h0);
      tick();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    check_output("burst_gap", 32'(grant), 32'h0);
    tick();
    check_output("burst_m0_grant", 32'(grant), 32'h1);
    check_output("burst_m0_adr", s_adr, 32'hDEAD_0000);
    m0_cyc = 0; m0_stb = 0;
    tick();

    $display("[TB] Watchdog forced termination");
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hFFFF_FA00;
    tick();
    for (int i = 1; i <= 8; i++) begin
      check_output("wd_m0_ack", 32'(m0_ack), (i == 8) ? 32'h1 : 32'h0);
      if (i == 8) check_output("wd_m0_dat", 32'(m0_dat_r), 32'hFF);
      if (i == 1) check_output("wd_flag_pre", 32'(timeout), 32'h0);
      tick();
    end
    check_output("wd_flag", 32'(timeout), 32'h1);
    check_output("wd_adr", timeout_adr, 32'hFFFF_FA00);
    check_output("wd_ack_after", 32'(m0_ack), 32'h0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    check_output("wd_flag_sticky", 32'(timeout), 32'h1);

    $display("[TB] Slave ACK on the timeout cycle");
    apply_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0020;
    tick();
    for (int i = 1; i <= 7; i++) begin
      check_output("late_no_ack", 32'(m0_ack), 32'h0);
      tick();
    end
    s_ack = 1; s_dat_r = 8'h33;
    #1;
    check_output("late_ack", 32'(m0_ack), 32'h1);
    check_output("late_dat", 32'(m0_dat_r), 32'h33);
    tick();
    check_output("late_flag", 32'(timeout), 32'h0);
    check_output("late_adr", timeout_adr, 32'h0);
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();

    $display("[TB] Asynchronous reset in OWN1");
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0300;
    tick();
    s_ack = 1; s_dat_r = 8'h77;
    #1;
    check_output("ar_pre_stb", 32'(s_stb), 32'h1);
    check_output("ar_pre_ack", 32'(m1_ack), 32'h1);
    rst = 1'b1;
    #1;
    check_output("ar_stb", 32'(s_stb), 32'h0);
    check_output("ar_ack", 32'(m1_ack), 32'h0);
    check_output("ar_grant", 32'(grant), 32'h0);
    s_ack = 0; m0_cyc = 1; m1_stb = 0;
    tick();
    rst = 1'b0;
    tick();
    check_output("ar_tie_m0", 32'(grant), 32'h1);
    m0_cyc = 0; m1_cyc = 0;
    tick();

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
